// File: rtl/player_motion_pkg.sv
// Shared definitions for the runner's vertical motion path.
//   - Movement codes produced by the key decoder and consumed by player_motion.
//   - Motion state encoding used by the motion FSM.
//   - mv_valid(): true for the codes that carry a command (001..100).
package player_motion_pkg;

  localparam logic [2:0] MV_NONE   = 3'b000;
  localparam logic [2:0] MV_BIG    = 3'b001;
  localparam logic [2:0] MV_SMALL  = 3'b010;
  localparam logic [2:0] MV_CROUCH = 3'b011;
  localparam logic [2:0] MV_DROP   = 3'b100;

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_RISE   = 3'd1,
    ST_HANG   = 3'd2,
    ST_FALL   = 3'd3,
    ST_DROP   = 3'd4,
    ST_CROUCH = 3'd5
  } motion_state_e;

  function automatic logic mv_valid(input logic [2:0] mv);
    return (mv != MV_NONE) && (mv <= MV_DROP);
  endfunction

endpackage

// File: rtl/motion_cmd_latch.sv
// Holds the most recent movement command until the next frame tick.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   tick_i        frame-step strobe; consumes and clears the pending command
//   movement_i    raw 3-bit movement code (one-cycle pulses)
//   cmd_o         command the motion FSM should apply on this tick
module motion_cmd_latch
  import player_motion_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic [2:0] movement_i,
  output logic [2:0] cmd_o
);

  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic       code_ok;

  always_comb begin
    code_ok = mv_valid(movement_i);
    // A code arriving together with the tick is newer than anything pending.
    cmd_o   = code_ok ? movement_i : pend_q;
    pend_d  = pend_q;
    if (tick_i) begin
      pend_d = MV_NONE;
    end else if (code_ok) begin
      pend_d = movement_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= MV_NONE;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Runner vertical motion: turns movement commands into height and
// crouch/airborne flags, advancing once per frame tick.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   tick         one-cycle frame-step strobe
//   movement     movement code from the key decoder
//   player_y     height above ground (0 = on ground)
//   crouching    high while crouched
//   airborne     high while rising, hanging, falling or dropping
//   busy         high whenever not standing on the ground
module player_motion
  import player_motion_pkg::*;
#(
  parameter int Y_W          = 6,
  parameter int BIG_JUMP_H   = 40,
  parameter int SMALL_JUMP_H = 20,
  parameter int HANG_TICKS   = 3,
  parameter int CROUCH_TICKS = 16,
  parameter int DROP_SPEED   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [2:0]     movement,
  output logic [Y_W-1:0] player_y,
  output logic           crouching,
  output logic           airborne,
  output logic           busy
);

  localparam int CNT_MAX = (CROUCH_TICKS > HANG_TICKS) ? CROUCH_TICKS : HANG_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CROUCH_INIT = CNT_W'(CROUCH_TICKS - 1);
  localparam logic [CNT_W-1:0] HANG_INIT   = CNT_W'(HANG_TICKS - 1);

  motion_state_e    state_q, state_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [Y_W-1:0]   peak_q, peak_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cmd;
  logic [Y_W:0]     y_inc;
  logic [Y_W:0]     y_dec;
  logic [Y_W-1:0]   y_drop;

  // One height-unit step either way is done one bit wider so the peak
  // comparison and the ground test never see a wrapped value.
  function automatic logic [Y_W-1:0] sat_drop(input logic [Y_W-1:0] y);
    logic signed [Y_W:0] diff;
    diff = $signed({1'b0, y}) - $signed((Y_W+1)'(DROP_SPEED));
    return (diff < 0) ? '0 : diff[Y_W-1:0];
  endfunction

  motion_cmd_latch u_cmd_latch (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (tick),
    .movement_i (movement),
    .cmd_o      (cmd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GROUND;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
    peak_q <= peak_d;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    y_inc   = {1'b0, y_q} + (Y_W+1)'(1);
    y_dec   = {1'b0, y_q} - (Y_W+1)'(1);
    y_drop  = sat_drop(y_q);
    if (tick) begin
      case (state_q)
        ST_GROUND: begin
          if (cmd == MV_BIG) begin
            state_d = ST_RISE;
            peak_d  = Y_W'(BIG_JUMP_H);
          end else if (cmd == MV_SMALL) begin
            state_d = ST_RISE;
            peak_d  = Y_W'(SMALL_JUMP_H);
          end else if (cmd == MV_CROUCH) begin
            state_d = ST_CROUCH;
            cnt_d   = CROUCH_INIT;
          end
        end
        ST_RISE: begin
          // Drop entry freezes height; descent starts on the next tick.
          if (cmd == MV_DROP) begin
            state_d = ST_DROP;
          end else begin
            y_d = y_inc[Y_W-1:0];
            if (y_inc == {1'b0, peak_q}) begin
              state_d = ST_HANG;
              cnt_d   = HANG_INIT;
            end
          end
        end
        ST_HANG: begin
          if (cmd == MV_DROP) begin
            state_d = ST_DROP;
          end else if (cnt_q == '0) begin
            state_d = ST_FALL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_FALL: begin
          if (cmd == MV_DROP) begin
            state_d = ST_DROP;
          end else begin
            y_d = y_dec[Y_W-1:0];
            if (y_dec == '0) begin
              state_d = ST_GROUND;
            end
          end
        end
        ST_DROP: begin
          y_d = y_drop;
          if (y_drop == '0) begin
            state_d = ST_GROUND;
          end
        end
        ST_CROUCH: begin
          y_d = '0;
          if (cmd == MV_BIG) begin
            state_d = ST_RISE;
            peak_d  = Y_W'(BIG_JUMP_H);
          end else if (cmd == MV_SMALL) begin
            state_d = ST_RISE;
            peak_d  = Y_W'(SMALL_JUMP_H);
          end else if (cmd == MV_CROUCH) begin
            cnt_d = CROUCH_INIT;
          end else if (cnt_q == '0) begin
            state_d = ST_GROUND;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_GROUND;
          y_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    player_y  = y_q;
    crouching = (state_q == ST_CROUCH);
    airborne  = (state_q == ST_RISE) || (state_q == ST_HANG) ||
                (state_q == ST_FALL) || (state_q == ST_DROP);
    busy      = (state_q != ST_GROUND);
  end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: each step queues the expected outputs,
// drives the step, then pops and compares once the outputs have settled.
module tb_player_motion;
  import player_motion_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [2:0] movement;
  logic [5:0] player_y;
  logic       crouching;
  logic       airborne;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] y;
    logic       cr;
    logic       air;
    logic       bz;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  player_motion dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .movement  (movement),
    .player_y  (player_y),
    .crouching (crouching),
    .airborne  (airborne),
    .busy      (busy)
  );

  task automatic push(input logic [5:0] y, input logic cr, input logic air,
                      input logic bz, input string tag);
    exp_t e;
    e.y = y; e.cr = cr; e.air = air; e.bz = bz; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got no expectation, need one");
    end else begin
      e = sb.pop_front();
      assert ({player_y, crouching, airborne, busy} === {e.y, e.cr, e.air, e.bz})
      else begin
        bad++;
        $error("FAIL %s: got y=%0d cr=%0b air=%0b busy=%0b, need y=%0d cr=%0b air=%0b busy=%0b",
               e.tag, player_y, crouching, airborne, busy, e.y, e.cr, e.air, e.bz);
      end
    end
  endtask

  // Drive one cycle of inputs; outputs are compared at the following negedge.
  task automatic step(input logic [2:0] mv, input logic tk);
    @(negedge clk);
    movement = mv;
    tick     = tk;
    @(negedge clk);
    movement = MV_NONE;
    tick     = 1'b0;
  endtask

  task automatic t_air(input logic [2:0] mv, input logic [5:0] y, input string tag);
    push(y, 1'b0, 1'b1, 1'b1, tag);
    step(mv, 1'b1);
    check();
  endtask

  task automatic t_gnd(input logic [2:0] mv, input string tag);
    push(6'd0, 1'b0, 1'b0, 1'b0, tag);
    step(mv, 1'b1);
    check();
  endtask

  task automatic t_cr(input logic [2:0] mv, input string tag);
    push(6'd0, 1'b1, 1'b0, 1'b1, tag);
    step(mv, 1'b1);
    check();
  endtask

  initial begin
    reset    = 1'b1;
    tick     = 1'b0;
    movement = MV_NONE;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(6'd0, 1'b0, 1'b0, 1'b0, "reset_state");
    check();

    // Big jump: pulse without tick leaves state alone, then full trajectory.
    push(6'd0, 1'b0, 1'b0, 1'b0, "big_pulse_no_tick");
    step(MV_BIG, 1'b0);
    check();
    t_air(MV_NONE, 6'd0, "big_enter");
    for (int i = 1; i <= 40; i++) t_air(MV_NONE, 6'(i), "big_rise");
    for (int i = 0; i < 3; i++) t_air(MV_NONE, 6'd40, "big_hang");
    for (int i = 39; i >= 1; i--) t_air(MV_NONE, 6'(i), "big_fall");
    t_gnd(MV_NONE, "big_land");

    // Small jump interrupted by a drop at y=10; saturating descent.
    step(MV_SMALL, 1'b0);
    t_air(MV_NONE, 6'd0, "small_enter");
    for (int i = 1; i <= 10; i++) t_air(MV_NONE, 6'(i), "small_rise");
    step(MV_DROP, 1'b0);
    t_air(MV_NONE, 6'd10, "drop_enter");
    t_air(MV_NONE, 6'd6, "drop_6");
    t_air(MV_NONE, 6'd2, "drop_2");
    t_gnd(MV_NONE, "drop_land");
    t_gnd(MV_NONE, "drop_stay_ground");

    // Crouch lasts 16 ticks after entry.
    step(MV_CROUCH, 1'b0);
    t_cr(MV_NONE, "crouch_enter");
    for (int i = 1; i <= 15; i++) t_cr(MV_NONE, "crouch_hold");
    t_gnd(MV_NONE, "crouch_end");

    // Crouch cancelled by a big jump sent together with the 5th tick.
    step(MV_CROUCH, 1'b0);
    t_cr(MV_NONE, "crouch2_enter");
    for (int i = 1; i <= 4; i++) t_cr(MV_NONE, "crouch2_hold");
    t_air(MV_BIG, 6'd0, "crouch_cancel_rise");
    t_air(MV_NONE, 6'd1, "cancel_rise_1");
    t_air(MV_DROP, 6'd1, "drop_at_1");
    t_gnd(MV_NONE, "drop_sat_zero");

    // Ignored commands: drop on ground, crouch during rise.
    step(MV_DROP, 1'b0);
    t_gnd(MV_NONE, "drop_on_ground");
    t_gnd(MV_NONE, "drop_pend_cleared");
    step(MV_SMALL, 1'b0);
    t_air(MV_NONE, 6'd0, "small2_enter");
    t_air(MV_NONE, 6'd1, "small2_rise");
    step(MV_CROUCH, 1'b0);
    t_air(MV_NONE, 6'd2, "crouch_in_rise");
    for (int i = 3; i <= 20; i++) t_air(MV_NONE, 6'(i), "small2_rise");
    for (int i = 0; i < 3; i++) t_air(MV_NONE, 6'd20, "small2_hang");
    for (int i = 19; i >= 1; i--) t_air(MV_NONE, 6'(i), "small2_fall");
    t_gnd(MV_NONE, "small2_land");

    // Newest code wins: small then big between ticks gives peak 40.
    step(MV_SMALL, 1'b0);
    step(MV_BIG, 1'b0);
    t_air(MV_NONE, 6'd0, "newest_enter");
    for (int i = 1; i <= 40; i++) t_air(MV_NONE, 6'(i), "newest_rise");
    for (int i = 0; i < 3; i++) t_air(MV_NONE, 6'd40, "newest_hang");
    t_air(MV_DROP, 6'd40, "hang_drop_enter");
    for (int i = 36; i >= 4; i -= 4) t_air(MV_NONE, 6'(i), "hang_drop");
    t_gnd(MV_NONE, "hang_drop_land");

    // Invalid code 111: no effect alone, and does not overwrite pend.
    step(3'b111, 1'b0);
    t_gnd(MV_NONE, "code111_ground");
    step(MV_CROUCH, 1'b0);
    step(3'b111, 1'b0);
    t_cr(MV_NONE, "code111_keeps_pend");
    t_air(MV_BIG, 6'd0, "crouch_to_big");
    for (int i = 1; i <= 12; i++) t_air(MV_NONE, 6'(i), "pre_reset_rise");

    // Reset mid-jump at y=12.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push(6'd0, 1'b0, 1'b0, 1'b0, "reset_mid_jump");
    check();
    t_gnd(MV_NONE, "after_reset_tick");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
